// File: rtl/collatz_pkg.sv
// Shared types and constants for the Collatz range-sweep controller.
package collatz_pkg;

  localparam int unsigned W               = 8;
  localparam int unsigned HI_TIMEOUT_DEF  = 4;
  localparam int unsigned RUN_TIMEOUT_DEF = 1023;
  localparam logic [W-1:0] COUNT_SAT      = {W{1'b1}};

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_HI,
    WAIT_LO,
    STEP,
    RECOVER,
    DONE
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at its all-ones value.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] SAT = {WIDTH{1'b1}};

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != SAT)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/collatz_sweep.sv
// Drives the Collatz core over an inclusive start-value range and tracks the
// longest-running start value plus the number of core timeouts.
module collatz_sweep #(
  parameter int unsigned W           = collatz_pkg::W,
  parameter int unsigned HI_TIMEOUT  = collatz_pkg::HI_TIMEOUT_DEF,
  parameter int unsigned RUN_TIMEOUT = collatz_pkg::RUN_TIMEOUT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         go,
  input  logic [W-1:0] lo,
  input  logic [W-1:0] hi,
  output logic         core_start,
  output logic [W-1:0] core_n,
  output logic         core_rst,
  input  logic         core_busy,
  input  logic [W-1:0] core_count,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W-1:0] max_count,
  output logic [W-1:0] max_n,
  output logic [W-1:0] timeouts
);

  import collatz_pkg::*;

  localparam int unsigned TMAX = (HI_TIMEOUT > RUN_TIMEOUT) ? HI_TIMEOUT : RUN_TIMEOUT;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  state_t        state, state_nx;
  logic [W-1:0]  cur, cur_nx, hi_q, cnt_q;
  logic [TW-1:0] timer;
  logic          cnt_vld, rec_q;
  logic          hi_to, run_to, last;
  logic          cap, samp, upd, to_inc;
  logic          start_d, rst_d, done_d, busy_d;

  assign hi_to  = (timer >= TW'(HI_TIMEOUT));
  assign run_to = (timer >= TW'(RUN_TIMEOUT));
  assign last   = (cur == hi_q);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (go) state_nx = (lo > hi) ? DONE : LAUNCH;
      LAUNCH:  state_nx = WAIT_HI;
      WAIT_HI: begin
        if (core_busy)  state_nx = WAIT_LO;
        else if (hi_to) state_nx = RECOVER;
      end
      WAIT_LO: begin
        if (!core_busy)  state_nx = STEP;
        else if (run_to) state_nx = RECOVER;
      end
      RECOVER: if (rec_q) state_nx = STEP;
      STEP:    state_nx = last ? DONE : LAUNCH;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // done is registered off the DONE state, so busy is stretched to cover it
  always_comb begin
    cap     = 1'b0;
    samp    = 1'b0;
    upd     = 1'b0;
    to_inc  = 1'b0;
    cur_nx  = cur;
    start_d = (state_nx == LAUNCH);
    rst_d   = (state_nx == RECOVER);
    done_d  = (state == DONE);
    busy_d  = (state_nx != IDLE) || (state == DONE);
    unique case (state)
      IDLE: begin
        cap = go;
        if (go) cur_nx = lo;
      end
      WAIT_LO: samp   = !core_busy;
      RECOVER: to_inc = !rec_q;
      STEP: begin
        upd = cnt_vld && (cnt_q > max_count);
        if (!last) cur_nx = cur + W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur        <= '0;
      hi_q       <= '0;
      cnt_q      <= '0;
      cnt_vld    <= 1'b0;
      rec_q      <= 1'b0;
      timer      <= '0;
      core_start <= 1'b0;
      core_rst   <= 1'b0;
      core_n     <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      max_count  <= '0;
      max_n      <= '0;
    end else begin
      cur        <= cur_nx;
      core_start <= start_d;
      core_rst   <= rst_d;
      done       <= done_d;
      busy       <= busy_d;
      rec_q      <= (state == RECOVER) && !rec_q;
      if (start_d) core_n <= cur_nx;
      if (cap) begin
        hi_q      <= hi;
        err       <= (lo > hi);
        max_count <= '0;
        max_n     <= '0;
      end
      if (upd) begin
        max_count <= cnt_q;
        max_n     <= cur;
      end
      if ((state == LAUNCH) || ((state == WAIT_HI) && core_busy)) begin
        timer <= '0;
      end else if ((state == WAIT_HI) || (state == WAIT_LO)) begin
        timer <= timer + TW'(1);
      end
      // a timed-out value leaves cnt_vld low so STEP skips the compare
      if (samp) begin
        cnt_q   <= core_count;
        cnt_vld <= 1'b1;
      end else if (state == LAUNCH) begin
        cnt_vld <= 1'b0;
      end
    end
  end

  sat_counter #(.WIDTH(W)) u_timeouts (
    .clk   (clk),
    .rst   (rst),
    .clr   (cap),
    .inc   (to_inc),
    .count (timeouts)
  );

endmodule

// File: doc/collatz_sweep.md
# collatz_sweep

Sweep controller that sits in front of the Collatz iteration core. It feeds the core one start value at a time over an inclusive range [lo, hi] and consumes each iteration count the core produces. It reports the longest-running start value, its step count, and how many start values failed to terminate. It turns the single-shot core into a range search that can be driven from a host register bank.

## Interface

Parameters:
- `W`, default 8: width of start values and iteration counts.
- `HI_TIMEOUT`, default 4: cycles allowed for `core_busy` to rise after launch.
- `RUN_TIMEOUT`, default 1023: cycles allowed for `core_busy` to fall once it has risen.

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `go`, in, 1: start a sweep; sampled only in IDLE.
- `lo`, in, W: first start value; captured on accepted `go`.
- `hi`, in, W: last start value, inclusive; captured on accepted `go`.
- `core_start`, out, 1: launch strobe to the core, held 1 cycle.
- `core_n`, out, W: start value to the core; stable from LAUNCH until the next LAUNCH.
- `core_rst`, out, 1: recovery reset to the core, 2-cycle pulse.
- `core_busy`, in, 1: core busy flag.
- `core_count`, in, W: core iteration count; valid in the cycle `core_busy` is seen low after having been high.
- `busy`, out, 1: sweep in progress.
- `done`, out, 1: 1-cycle pulse when a sweep ends.
- `err`, out, 1: set when the captured range is invalid (`lo > hi`); held until the next accepted `go`.
- `max_count`, out, W: largest count seen in the sweep.
- `max_n`, out, W: start value that produced `max_count`.
- `timeouts`, out, W: number of start values that timed out; saturates at 2^W-1.

## Operation

- **States:** IDLE, LAUNCH, WAIT_HI, WAIT_LO, STEP, RECOVER, DONE.
- **IDLE:**
  - If `go`=1: capture `lo`/`hi`, set `cur`=`lo`, clear `max_count`/`max_n`/`timeouts`/`err`.
  - If `lo > hi`: set `err`=1 and go to DONE.
  - Otherwise go to LAUNCH.
- **LAUNCH:** `core_n`=`cur`, `core_start`=1. Clear the timer and go to WAIT_HI.
- **WAIT_HI:**
  - `core_busy`=1 → WAIT_LO with the timer cleared.
  - Timer reaches `HI_TIMEOUT` → RECOVER.
- **WAIT_LO:**
  - `core_busy`=0 → sample `core_count`, then STEP.
  - Timer reaches `RUN_TIMEOUT` → RECOVER.
- **RECOVER:**
  - Assert `core_rst` for 2 cycles and increment `timeouts` (saturating).
  - Then go to STEP without a compare; the timed-out value never updates the max.
- **STEP:**
  - If the sampled count > `max_count` (strictly greater), update `max_count` and `max_n`. Ties keep the earlier, lower N.
  - If `cur == hi` → DONE; else `cur`+1 → LAUNCH.
  - The equality test happens before the increment, so `hi`=2^W-1 never wraps `cur` to 0.
- **DONE:** `done`=1 for 1 cycle, then IDLE. Results stay held until the next accepted `go`.
- **Ignored inputs:**
  - `go` outside IDLE is ignored.
  - Changes to `lo`/`hi` after capture have no effect.
- **Core hazards:** start values 0 and 1, plus 8-bit overflow in the core, can make the core loop forever. The timeouts are the only protection against that.

## Timing

- **Reset:**
  - All outputs are 0, the state is IDLE, and the timer and `cur` are 0.
  - `rst` in the middle of a sweep aborts it with no `done` pulse.
  - `core_rst` is not asserted by `rst`; the core shares the system reset.
- **Per start value:** latency is 1 (LAUNCH) + t_rise + t_run + 1 (STEP) cycles.
- **Sweep start:** `busy` rises the cycle after an accepted `go`.
- **Sweep end:** `busy` falls together with the `done` pulse cycle ending, i.e. `busy`=0 in the cycle after `done`.
- **Invalid range:** `go` with `lo > hi` gives `done` 2 cycles after `go`, with `err`=1 and all results 0.
- **Timer:** counts the cycles spent in the current wait state. The timeout compare is `>=` against the parameter.

## Structure

- **Shared package** `collatz_pkg`:
  - State enum.
  - `W`.
  - Default timeout constants.
  - `COUNT_SAT` = 2^W-1.
- **Sub-module** `sat_counter` (width, increment, clear, saturate) is used for `timeouts`. The timer is a plain counter.
- **Datapath** (compare/update register set for `max_count`/`max_n`) stays in the top module.

## Test plan

All scenarios use a behavioural core model with 1-cycle rise and a run time of N cycles.

1. **Basic sweep.** Model count = N. lo=3, hi=10 → `done` pulse, `max_count`=10, `max_n`=10, `timeouts`=0, `err`=0.
2. **Ties.** Model count = 5 for every N. lo=20, hi=30 → `max_count`=5, `max_n`=20.
3. **Timeout.** Model never drops busy for N=7. lo=5, hi=9, count = N → `timeouts`=1, `core_rst` high 2 cycles, `max_n`=9, and the sweep completes.
4. **Invalid range.** lo=9, hi=4 → `err`=1, `done` 2 cycles after `go`, `max_count`=0, no `core_start` pulse.
5. **Top-end wrap.** lo=250, hi=255, count = N → exactly 6 `core_start` pulses, `max_n`=255, terminates.
6. **Ignored `go` and mid-sweep reset.**
   - `go` pulsed during a sweep → ignored, results unchanged.
   - `rst` asserted mid-sweep → all outputs 0 next cycle, no `done` pulse.
